// File: rtl/instr_loader.sv
// instr_loader: streams instruction words into a DEPTH-entry store, then serves them to fetch.
module instr_loader #(
  parameter int DATA_W = 8,
  parameter int DEPTH = 8,
  parameter logic [DATA_W-1:0] END_WORD = {DATA_W{1'b1}},
  parameter logic [DATA_W-1:0] NOP_WORD = {DATA_W{1'b0}},
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [CNT_W-1:0]  count,
  output logic              prog_ready,
  output logic              full_term
);
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
  state_t state, state_nxt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic accept, is_end, last;
  logic [ADDR_W-1:0] wr_idx;
  assign in_ready = state == LOAD;
  assign prog_ready = state == DONE;
  assign accept = in_valid && in_ready;
  assign is_end = in_data == END_WORD;
  assign last = count == CNT_W'(DEPTH - 1);
  assign wr_idx = count[ADDR_W-1:0];
  // Count doubles as the write pointer; it also masks stale slots from earlier loads.
  assign rd_data = (CNT_W'(rd_addr) < count) ? mem[rd_addr] : NOP_WORD;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    state_nxt = (state == LOAD) ? ((accept && (is_end || last)) ? DONE : LOAD)
                                : (start ? LOAD : state);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= NOP_WORD;
      count <= '0;
      full_term <= 1'b0;
    end else if (start && state != LOAD) begin
      count <= '0;
      full_term <= 1'b0;
    end else if (accept && !is_end) begin
      mem[wr_idx] <= in_data;
      count <= count + 1'b1;
      if (last) full_term <= 1'b1;
    end
endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: table vectors, hand corner sequences and a random run against a queue model.
module tb_instr_loader;
  logic clk = 0, reset = 1;
  logic start = 0, in_valid = 0, in_ready, prog_ready, full_term;
  logic [7:0] in_data = 0, rd_data;
  logic [2:0] rd_addr = 0;
  logic [3:0] count;
  logic start2 = 0, in_valid2 = 0, in_ready2, prog_ready2, full_term2;
  logic [15:0] in_data2 = 0, rd_data2;
  logic [2:0] rd_addr2 = 0, count2;
  int n_cmp = 0, n_err = 0;
  logic [7:0] q[$];
  bit m_load = 0, m_done = 0, m_full = 0;

  always #10 clk = ~clk;

  instr_loader dut (.clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .rd_addr(rd_addr), .rd_data(rd_data),
    .count(count), .prog_ready(prog_ready), .full_term(full_term));

  instr_loader #(.DATA_W(16), .DEPTH(5), .END_WORD(16'hFFFF), .NOP_WORD(16'h0000)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .in_valid(in_valid2), .in_data(in_data2),
    .in_ready(in_ready2), .rd_addr(rd_addr2), .rd_data(rd_data2), .count(count2),
    .prog_ready(prog_ready2), .full_term(full_term2));

  typedef struct {
    logic st; logic v; logic [7:0] d;
    logic er; logic ep; logic [3:0] ec; logic ef;
  } vec_t;
  vec_t tv[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    q.delete(); m_load = 0; m_done = 0; m_full = 0;
  endtask

  // Spec-level behaviour: a queue holds the current program; reads past its end are NOP.
  task automatic model_edge();
    if (!m_load) begin
      if (start) begin q.delete(); m_load = 1; m_done = 0; m_full = 0; end
    end else if (in_valid) begin
      if (in_data == 8'hFF) begin m_load = 0; m_done = 1; end
      else begin
        q.push_back(in_data);
        if (q.size() == 8) begin m_load = 0; m_done = 1; m_full = 1; end
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, " in_ready"}, in_ready, m_load);
    chk({tag, " prog_ready"}, prog_ready, m_done);
    chk({tag, " count"}, count, q.size());
    chk({tag, " full_term"}, full_term, m_full);
    for (int a = 0; a < 8; a++) begin
      rd_addr = a[2:0];
      #1;
      chk($sformatf("%s rd_data[%0d]", tag, a), rd_data, a < q.size() ? q[a] : 8'h00);
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
    @(negedge clk);
  endtask

  task automatic drive(input logic st, input logic v, input logic [7:0] d);
    start = st; in_valid = v; in_data = d;
  endtask

  initial begin
    logic [7:0] w[7];
    w[0] = 8'h88; w[1] = 8'h89; w[2] = 8'h8A; w[3] = 8'h8C;
    w[4] = 8'h90; w[5] = 8'hA8; w[6] = 8'h89;
    tv[0] = '{1, 0, 8'h00, 1, 0, 0, 0};
    for (int i = 0; i < 7; i++) tv[i+1] = '{0, 1, w[i], 1, 0, 4'(i + 1), 0};
    tv[8] = '{0, 1, 8'hFF, 0, 1, 7, 0};
    tv[9] = '{0, 1, 8'h55, 0, 1, 7, 0};
    tv[10] = '{0, 0, 8'h00, 0, 1, 7, 0};

    #2;
    check_all("reset");
    chk("reset dut2 count", count2, 0);
    @(negedge clk); @(negedge clk);
    reset = 0;

    for (int i = 0; i < 11; i++) begin
      drive(tv[i].st, tv[i].v, tv[i].d);
      step($sformatf("vec%0d", i));
      chk($sformatf("vec%0d tbl in_ready", i), in_ready, tv[i].er);
      chk($sformatf("vec%0d tbl prog_ready", i), prog_ready, tv[i].ep);
      chk($sformatf("vec%0d tbl count", i), count, tv[i].ec);
      chk($sformatf("vec%0d tbl full_term", i), full_term, tv[i].ef);
    end
    for (int a = 0; a < 8; a++) begin
      rd_addr = a[2:0];
      #1;
      chk($sformatf("prog7 rd[%0d]", a), rd_data, a < 7 ? w[a] : 8'h00);
    end

    drive(1, 0, 0); step("reload start");
    drive(0, 1, 8'h11); step("reload w0");
    drive(0, 1, 8'hFF); step("reload end");
    rd_addr = 0; #1; chk("reload rd0", rd_data, 8'h11);
    rd_addr = 1; #1; chk("reload rd1 masked", rd_data, 8'h00);
    chk("reload count", count, 1);
    @(negedge clk);

    drive(1, 0, 0); step("full start");
    for (int i = 1; i <= 8; i++) begin
      drive(0, 1, 8'(i));
      step($sformatf("full w%0d", i));
    end
    chk("full full_term", full_term, 1);
    chk("full count", count, 8);
    chk("full prog_ready", prog_ready, 1);
    drive(0, 1, 8'h09); step("full 9th");
    chk("full 9th in_ready", in_ready, 0);
    rd_addr = 0; #1; chk("full mem0 kept", rd_data, 8'h01);
    @(negedge clk);

    drive(1, 1, 8'h21); step("gap start+valid");
    chk("gap word not consumed", count, 0);
    drive(0, 1, 8'h21); step("gap w0");
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 8'h77); step("gap idle");
    end
    chk("gap count held", count, 1);
    drive(0, 1, 8'h22); step("gap w1");
    chk("gap count", count, 2);
    drive(0, 1, 8'hFF); step("gap end");

    drive(1, 0, 0); step("empty start");
    drive(0, 1, 8'hFF); step("empty end");
    chk("empty count", count, 0);
    chk("empty prog_ready", prog_ready, 1);

    drive(1, 0, 0); step("rst start");
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 8'h40 + 8'(i)); step("rst w");
    end
    drive(0, 1, 8'h43);
    #3 reset = 1;
    model_clear();
    #1;
    check_all("midrst");
    @(negedge clk);
    reset = 0;
    drive(0, 1, 8'h44); step("post-rst no start");
    chk("post-rst count", count, 0);
    step("post-rst no start2");

    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(15) == 0, $urandom_range(1),
            $urandom_range(5) == 0 ? 8'hFF : 8'($urandom_range(254)));
      step($sformatf("rand%0d", n));
    end
    drive(0, 0, 0);

    start2 = 1;
    @(negedge clk);
    start2 = 0;
    chk("p16 in_ready", in_ready2, 1);
    in_valid2 = 1;
    for (int i = 0; i < 5; i++) begin
      in_data2 = 16'h1000 + 16'(i * 16'h111);
      @(negedge clk);
    end
    in_valid2 = 0;
    chk("p16 full_term", full_term2, 1);
    chk("p16 count", count2, 5);
    chk("p16 prog_ready", prog_ready2, 1);
    for (int a = 0; a < 8; a++) begin
      rd_addr2 = a[2:0];
      #1;
      chk($sformatf("p16 rd[%0d]", a), rd_data2, a < 5 ? 16'h1000 + 16'(a * 16'h111) : 16'h0000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
